sd_cmd_engine: RTL and testbench
================================

Name: sd_cmd_engine

Overview:
- Host-side SD CMD-line engine that serialises one 48-bit command frame onto the registered CMD pad and optionally captures the card's 48-bit response.
- Sits between the top-level control state machine and the registered CMD pad I/O cell, replacing the hand-driven level control of the CMD pin.
- Computes CRC7 on transmit, checks CRC7 and end bit on receive, and enforces a response timeout.
- One bit per `clk` cycle. `clk` is the SD bit clock; `sd_clk` generation stays outside this block.

Parameters:
- RESP_TIMEOUT, 64, max `clk` cycles after the command end bit to wait for a response start bit (minimum 2).
- TIMEOUT_W, 8, counter width; must satisfy 2**TIMEOUT_W > RESP_TIMEOUT.

Ports:
- clk  in  1  bit clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- cmd_trigger  in  1  start a command; sampled only in IDLE.
- cmd_index  in  6  command index; captured on accepted trigger.
- cmd_arg  in  32  argument; captured on accepted trigger.
- resp_en  in  1  1 = expect a 48-bit response; captured on accepted trigger.
- busy  out  1  high from the cycle after acceptance until `done`.
- done  out  1  one-cycle pulse at completion.
- resp  out  48  captured response, MSB first; held until the next accepted trigger.
- resp_crc_err  out  1  valid with `done`; held until the next accepted trigger.
- resp_timeout  out  1  valid with `done`; held until the next accepted trigger.
- sd_cmdOut  out  1  pad output data (pad registers it).
- sd_cmdOutEn  out  1  pad output enable.
- sd_cmdIn  in  1  registered pad input.

Behaviour:
- Reset values:
  - busy=0, done=0.
  - resp=0, resp_crc_err=0, resp_timeout=0.
  - sd_cmdOut=1, sd_cmdOutEn=0, so the line is released.
  - State IDLE; all counters 0.
- Reset asserted mid-operation aborts immediately to these values. No `done` is produced for the aborted command.
- Frame layout, sent MSB first:
  - start bit 0
  - transmission bit 1
  - cmd_index[5:0]
  - cmd_arg[31:0]
  - CRC7 computed over the preceding 40 bits
  - end bit 1
- CRC7 polynomial is x^7+x^3+1, initial value 0.
- States:
  - IDLE: trigger=1 latches the inputs, clears resp, resp_crc_err and resp_timeout, and moves to TX.
  - TX: for 48 cycles, sd_cmdOutEn=1 and sd_cmdOut = frame bit k, k=47..0. The first bit is presented on the cycle after acceptance.
  - After the end bit: resp_en=0 goes to DONE; resp_en=1 goes to WAIT.
  - WAIT:
    - sd_cmdOutEn=0 and sd_cmdOut=1.
    - The first 2 cycles are a turnaround in which sd_cmdIn is ignored.
    - After turnaround, sd_cmdIn==0 is the start bit: store it as resp[47] and go to RX.
    - If RESP_TIMEOUT cycles elapse since the end bit with no start bit, set resp_timeout=1 and go to DONE.
  - RX: shift in 47 further bits. After the 48th bit, go to CHECK.
  - CHECK (one cycle): resp_crc_err = (CRC7 of resp[47:8] != resp[7:1]) or (resp[0]==0). Then go to DONE.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- `busy` is 1 in TX, WAIT, RX and CHECK.
- `done` and the next trigger may coincide. A trigger while not in IDLE, including during DONE, is ignored.
- Latency:
  - Without response: done fires 49 cycles after the accept edge.
  - With response: done fires 48 + (wait cycles) + 48 + 1 + 1 cycles after the accept edge.
- R3/R2-type responses are not validated. The caller ignores resp_crc_err for R3. R2 (136-bit) is out of scope.

Optional Feature:
- Macro: SD_CMD_RESP_CRC_EN.
- Defined: RX runs the CRC7 sub-module on incoming bits and CHECK behaves as above.
- Undefined:
  - No receive CRC logic is built.
  - resp_crc_err = (resp[0]==0) only.
  - The CHECK state is still taken, so latency is unchanged.

Decomposition:
- Package `sd_pkg`:
  - CRC7 polynomial constant 7'h09.
  - FRAME_LEN=48, TURNAROUND=2.
  - State enum {IDLE, TX, WAIT, RX, CHECK, DONE}.
- Sub-module `sd_crc7`: serial CRC7 with inputs clk, rst, clr, en, din and output crc[6:0].
  - Instanced once for TX.
  - Instanced once for RX, under the macro.

Test Plan:
- CMD0, arg 0, resp_en=0 -> sd_cmdOut serial = 48'h400000000095; OutEn high exactly 48 cycles; done 49 cycles after accept; resp_timeout=0.
- CMD8, arg 32'h1AA, resp_en=1; card model drives 48'h08000001AA13 after 5 idle cycles -> resp=48'h08000001AA13, resp_crc_err=0, resp_timeout=0.
- Same as above with response bit 20 flipped -> resp_crc_err=1 with macro defined, 0 without. Separately, end bit forced 0 -> resp_crc_err=1 in both builds.
- resp_en=1, line held high -> done with resp_timeout=1 exactly RESP_TIMEOUT+1 cycles after the end bit; resp=0.
- Line driven 0 during turnaround, then high -> no false start; resp_timeout=1.
- Trigger pulsed during TX, then rst asserted at TX bit 20 -> second trigger ignored; outputs at reset values asynchronously; next trigger sends a full, correct frame.

Source files
------------

// File: rtl/sd_cmd_engine_pkg.sv
// sd_pkg: shared constants and state encoding for the SD CMD-line engine
package sd_pkg;
  localparam logic [6:0] CRC7_POLY = 7'h09;
  localparam int FRAME_LEN = 48;
  localparam int TURNAROUND = 2;
  typedef enum logic [2:0] {IDLE, TX, WAIT, RX, CHECK, DONE} state_t;
endpackage

// File: rtl/sd_cmd_engine_if.sv
// sd_cmd_engine_if: host-side command/response bundle of the SD CMD engine
interface sd_cmd_engine_if;
  logic        cmd_trigger;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        resp_en;
  logic        busy;
  logic        done;
  logic [47:0] resp;
  logic        resp_crc_err;
  logic        resp_timeout;
  modport master(output cmd_trigger, cmd_index, cmd_arg, resp_en,
                 input busy, done, resp, resp_crc_err, resp_timeout);
  modport slave(input cmd_trigger, cmd_index, cmd_arg, resp_en,
                output busy, done, resp, resp_crc_err, resp_timeout);
endinterface

// File: rtl/sd_cmd_engine_crc7.sv
// sd_crc7: serial CRC7 (x^7+x^3+1), MSB first, zero initial value
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);
  logic w_fb;
  assign w_fb = din ^ crc[6];
  always_ff @(posedge clk or posedge rst)
    if (rst) crc <= 7'h0;
    else if (clr) crc <= 7'h0;
    else if (en) crc <= {crc[5:0], 1'b0} ^ (w_fb ? CRC7_POLY : 7'h0);
endmodule

// File: rtl/sd_cmd_engine.sv
// sd_cmd_engine: serialises a 48-bit SD command and captures an optional 48-bit response
// Define SD_CMD_RESP_CRC_EN to build the receive-side CRC7 check.
module sd_cmd_engine
  import sd_pkg::*;
#(
  parameter int RESP_TIMEOUT = 64,
  parameter int TIMEOUT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  sd_cmd_engine_if.slave   host,
  output logic             sd_cmdOut,
  output logic             sd_cmdOutEn,
  input  logic             sd_cmdIn
);
  state_t                 r_state;
  logic [38:0]            r_tx;
  logic [5:0]             r_cnt;
  logic [TIMEOUT_W-1:0]   r_wcnt;
  logic [47:0]            r_resp;
  logic                   r_resp_en, r_busy, r_done, r_crc_err, r_timeout, r_out, r_oe;
  logic [6:0]             w_tx_crc;
  logic                   w_accept, w_tx_en, w_start, w_crc_bit, w_crc_bad;

  assign w_accept  = r_state == IDLE && host.cmd_trigger;
  assign w_tx_en   = r_state == TX && r_cnt < 6'd40;
  assign w_start   = r_state == WAIT && r_wcnt > TIMEOUT_W'(TURNAROUND) && !sd_cmdIn;
  assign w_crc_bit = w_tx_crc[3'(6'd46 - r_cnt)];

  sd_crc7 u_tx_crc (.clk, .rst, .clr(w_accept), .en(w_tx_en), .din(r_tx[38]), .crc(w_tx_crc));

`ifdef SD_CMD_RESP_CRC_EN
  logic [6:0] w_rx_crc;
  logic       w_rx_en;
  assign w_rx_en   = w_start || (r_state == RX && r_cnt < 6'd40);
  assign w_crc_bad = w_rx_crc != r_resp[7:1];
  sd_crc7 u_rx_crc (.clk, .rst, .clr(w_accept), .en(w_rx_en), .din(sd_cmdIn), .crc(w_rx_crc));
`else
  assign w_crc_bad = 1'b0;
`endif

  // r_cnt counts frame bits already on the line (TX) or already captured (RX)
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state   <= IDLE;
      r_tx      <= '0;
      r_cnt     <= '0;
      r_wcnt    <= '0;
      r_resp    <= '0;
      r_resp_en <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_crc_err <= 1'b0;
      r_timeout <= 1'b0;
      r_out     <= 1'b1;
      r_oe      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (host.cmd_trigger) begin
          r_tx      <= {1'b1, host.cmd_index, host.cmd_arg};
          r_resp_en <= host.resp_en;
          r_resp    <= '0;
          r_crc_err <= 1'b0;
          r_timeout <= 1'b0;
          r_busy    <= 1'b1;
          r_out     <= 1'b0;
          r_oe      <= 1'b1;
          r_cnt     <= 6'd1;
          r_state   <= TX;
        end
        TX: begin
          r_cnt <= r_cnt + 6'd1;
          r_tx  <= r_tx << 1;
          r_out <= r_cnt < 6'd40 ? r_tx[38] : r_cnt < 6'd47 ? w_crc_bit : 1'b1;
          if (r_cnt == 6'(FRAME_LEN)) begin
            r_oe    <= 1'b0;
            r_wcnt  <= TIMEOUT_W'(1);
            r_state <= r_resp_en ? WAIT : DONE;
          end
        end
        WAIT: begin
          r_wcnt <= r_wcnt + TIMEOUT_W'(1);
          if (w_start) begin
            r_resp  <= {r_resp[46:0], sd_cmdIn};
            r_cnt   <= 6'd1;
            r_state <= RX;
          end else if (r_wcnt == TIMEOUT_W'(RESP_TIMEOUT)) begin
            r_timeout <= 1'b1;
            r_state   <= DONE;
          end
        end
        RX: begin
          r_resp <= {r_resp[46:0], sd_cmdIn};
          r_cnt  <= r_cnt + 6'd1;
          if (r_cnt == 6'(FRAME_LEN - 1)) r_state <= CHECK;
        end
        CHECK: begin
          r_crc_err <= w_crc_bad || !r_resp[0];
          r_state   <= DONE;
        end
        DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
          r_wcnt  <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end

  assign host.busy         = r_busy;
  assign host.done         = r_done;
  assign host.resp         = r_resp;
  assign host.resp_crc_err = r_crc_err;
  assign host.resp_timeout = r_timeout;
  assign sd_cmdOut         = r_out;
  assign sd_cmdOutEn       = r_oe;
endmodule

// File: tb/tb_sd_cmd_engine.sv
// tb_sd_cmd_engine: randomized and directed checks of sd_cmd_engine against a frame-level model
module tb_sd_cmd_engine;
  localparam int RT = 20;
`ifdef SD_CMD_RESP_CRC_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sd_cmdOut, sd_cmdOutEn;
  logic sd_cmdIn = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  sd_cmd_engine_if h();

  sd_cmd_engine #(.RESP_TIMEOUT(RT), .TIMEOUT_W(5)) dut (
    .clk(clk), .rst(rst), .host(h),
    .sd_cmdOut(sd_cmdOut), .sd_cmdOutEn(sd_cmdOutEn), .sd_cmdIn(sd_cmdIn)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // CRC7 as the remainder of m(x)*x^7 divided by x^7+x^3+1
  function automatic logic [6:0] crc7(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'b0};
    for (int i = 46; i >= 7; i--) if (r[i]) r ^= 47'h89 << (i - 7);
    return r[6:0];
  endfunction

  function automatic logic [47:0] mk_resp(input logic [5:0] idx, input logic [31:0] body);
    logic [39:0] m;
    m = {2'b00, idx, body};
    return {m, crc7(m), 1'b1};
  endfunction

  // mode: 0 card answers after d idle cycles, 1 silent, 2 drives low in turnaround then silent
  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic ren,
                         input int mode, input int d, input logic [47:0] card,
                         output logic [47:0] f);
    logic [47:0] exp_frame, exp_resp;
    logic        exp_err, exp_to, oe_ok, busy_ok;
    int          exp_t, done_t, oe_cnt, j;
    exp_frame = {2'b01, idx, arg, crc7({2'b01, idx, arg}), 1'b1};
    exp_t     = !ren ? 49 : mode != 0 ? 49 + RT : 98 + d;
    exp_resp  = ren && mode == 0 ? card : 48'h0;
    exp_to    = ren && mode != 0;
    exp_err   = ren && mode == 0 && (!card[0] || (CRC_EN && crc7(card[47:8]) != card[7:1]));
    f = '0; oe_cnt = 0; done_t = -1; oe_ok = 1'b1; busy_ok = 1'b1;
    h.cmd_index = idx; h.cmd_arg = arg; h.resp_en = ren; h.cmd_trigger = 1'b1;
    for (int t = 0; t < 300 && done_t < 0; t++) begin
      @(posedge clk); #1;
      h.cmd_trigger = 1'b0;
      if (sd_cmdOutEn) begin f = {f[46:0], sd_cmdOut}; oe_cnt++; end
      oe_ok   &= (sd_cmdOutEn == (t < 48)) && (sd_cmdOutEn || sd_cmdOut);
      busy_ok &= h.busy == (t < exp_t);
      if (h.done) done_t = t;
      j = t + 1 - 49 - d;
      sd_cmdIn = t < 47 ? 1'($urandom) :
                 mode == 0 && j >= 0 && j < 48 ? card[47 - j] :
                 mode == 2 && (t == 48 || t == 49) ? 1'b0 : 1'b1;
    end
    sd_cmdIn = 1'b1;
    chk("latency", 48'(done_t), 48'(exp_t));
    chk("frame", f, exp_frame);
    chk("oe_cycles", 48'(oe_cnt), 48'd48);
    chk("oe_window", oe_ok, 1'b1);
    chk("busy", busy_ok, 1'b1);
    chk("resp", h.resp, exp_resp);
    chk("crc_err", h.resp_crc_err, exp_err);
    chk("timeout", h.resp_timeout, exp_to);
  endtask

  initial begin
    logic [47:0] f, ef, gf, card;
    logic        quiet;
    int          mode, corrupt;
    h.cmd_trigger = 1'b0; h.cmd_index = '0; h.cmd_arg = '0; h.resp_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", h.busy, 1'b0);
    chk("rst_done", h.done, 1'b0);
    chk("rst_resp", h.resp, 48'h0);
    chk("rst_out", {sd_cmdOut, sd_cmdOutEn}, 2'b10);
    rst = 1'b0;

    run_cmd(6'd0, 32'h0, 1'b0, 0, 5, 48'h0, f);
    chk("cmd0_const", f, 48'h400000000095);
    card = 48'h08000001AA13;
    run_cmd(6'd8, 32'h1AA, 1'b1, 0, 5, card, f);
    run_cmd(6'd8, 32'h1AA, 1'b1, 0, 5, card ^ (48'h1 << 20), f);
    run_cmd(6'd8, 32'h1AA, 1'b1, 0, 5, card & ~48'h1, f);
    run_cmd(6'd8, 32'h1AA, 1'b1, 1, 5, card, f);
    run_cmd(6'd8, 32'h1AA, 1'b1, 2, 5, card, f);
    run_cmd(6'd55, 32'h0, 1'b1, 0, 2, mk_resp(6'd55, 32'h120), f);
    run_cmd(6'd17, 32'h200, 1'b1, 0, RT - 1, mk_resp(6'd17, 32'h900), f);

    h.cmd_index = 6'd17; h.cmd_arg = $urandom(); h.resp_en = 1'b1; h.cmd_trigger = 1'b1;
    ef = {2'b01, h.cmd_index, h.cmd_arg, crc7({2'b01, h.cmd_index, h.cmd_arg}), 1'b1};
    gf = '0;
    for (int t = 0; t <= 20; t++) begin
      @(posedge clk); #1;
      h.cmd_trigger = t == 5;
      if (t == 5) h.cmd_index = 6'd33;
      gf = {gf[46:0], sd_cmdOut};
    end
    chk("abort_prefix", gf[20:0], ef[47:27]);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", h.busy, 1'b0);
    chk("abort_flags", {h.done, h.resp_crc_err, h.resp_timeout}, 3'b000);
    chk("abort_resp", h.resp, 48'h0);
    chk("abort_out", {sd_cmdOut, sd_cmdOutEn}, 2'b10);
    h.cmd_trigger = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    quiet = 1'b1;
    for (int t = 0; t < 60; t++) begin
      @(posedge clk); #1;
      quiet &= !h.done && !sd_cmdOutEn && !h.busy;
    end
    chk("abort_quiet", quiet, 1'b1);
    run_cmd(6'd41, 32'hDEADBEEF, 1'b0, 0, 5, 48'h0, f);

    for (int k = 0; k < 20; k++) begin
      mode    = $urandom_range(0, 5) < 4 ? 0 : $urandom_range(1, 2);
      corrupt = $urandom_range(0, 3);
      card    = mk_resp(6'($urandom), $urandom());
      if (corrupt == 1) card ^= 48'h1 << $urandom_range(1, 46);
      if (corrupt == 2) card[0] = 1'b0;
      run_cmd(6'($urandom), $urandom(), 1'($urandom), mode, $urandom_range(2, RT - 1), card, f);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
